// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte engine among four packet sources.
// One source owns the engine per packet; a programmable idle gap separates packets.
module uart_tx_sched #(
   parameter logic [15:0] GAP_CYCLES   = 16'd434,
   parameter logic [15:0] DONE_TIMEOUT = 16'd5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] src_data,
   input  logic [3:0]  src_last,
   output logic [3:0]  grant,
   output logic [3:0]  byte_ack,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  g_idx_q, g_idx_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [3:0]  byte_ack_q, byte_ack_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        err_q, err_d;
   logic        last_q, last_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;

   logic [2:0]  pick;
   logic [7:0]  sel_data;
   logic        sel_req;
   logic        sel_last;
   logic        wait_to;
   logic        gap_end;
   logic        enter_gap;

   // Returns {found, index} of the first request at or after ptr, wrapping 3->0.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign pick     = rr_pick(req, rr_ptr_q);
   assign sel_data = src_data[{g_idx_q, 3'b000} +: 8];
   assign sel_req  = req[g_idx_q];
   assign sel_last = src_last[g_idx_q];
   assign wait_to  = (wait_cnt_q == DONE_TIMEOUT - 16'd1);
   assign gap_end  = (GAP_CYCLES == 16'd0) || (gap_cnt_q == GAP_CYCLES - 16'd1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      g_idx_d    = g_idx_q;
      rr_ptr_d   = rr_ptr_q;
      last_d     = last_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      byte_ack_d = 4'b0000;
      err_d      = 1'b0;
      wait_cnt_d = 16'd0;
      gap_cnt_d  = 16'd0;
      enter_gap  = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick[2]) begin
               g_idx_d = pick[1:0];
               grant_d = 4'b0001 << pick[1:0];
               state_d = SEND;
            end
         end
         SEND: begin
            if (sel_req) begin
               tx_start_d = 1'b1;
               byte_ack_d = grant_q;
               tx_data_d  = sel_data;
               last_d     = sel_last;
               state_d    = WAIT;
            end else begin
               enter_gap = 1'b1;
            end
         end
         WAIT: begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
            // A done arriving together with the timeout wins; no error then.
            if (tx_done) begin
               if (last_q) enter_gap = 1'b1;
               else        state_d   = SEND;
            end else if (wait_to) begin
               err_d     = 1'b1;
               enter_gap = 1'b1;
            end
         end
         GAP: begin
            gap_cnt_d = (gap_cnt_q == 16'hFFFF) ? gap_cnt_q : gap_cnt_q + 16'd1;
            if (gap_end) begin
               gap_cnt_d = 16'd0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_gap) begin
         grant_d  = 4'b0000;
         rr_ptr_d = g_idx_q + 2'd1;
         state_d  = GAP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         g_idx_q    <= 2'd0;
         rr_ptr_q   <= 2'd0;
         byte_ack_q <= 4'b0000;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         err_q      <= 1'b0;
         last_q     <= 1'b0;
         wait_cnt_q <= 16'd0;
         gap_cnt_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         g_idx_q    <= g_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_ack_q <= byte_ack_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
         last_q     <= last_d;
         wait_cnt_q <= wait_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign grant    = grant_q;
   assign byte_ack = byte_ack_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: source and byte-engine models plus event logs,
// with cycle-exact expectations worked out by hand from the scheduler timing.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] src_data;
   logic [3:0]  src_last;
   logic [3:0]  grant;
   logic [3:0]  byte_ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        err;

   uart_tx_sched #(.GAP_CYCLES(16'd434), .DONE_TIMEOUT(16'd5000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .src_data (src_data),
      .src_last (src_last),
      .grant    (grant),
      .byte_ack (byte_ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Source models: each source walks its byte list, advancing on byte_ack.
   logic [31:0] sbytes [4];
   logic [3:0]  smask  [4];
   int          sl     [4];
   int          sp     [4];
   bit          en     [4];

   initial begin
      req = 4'b0000;
      src_data = 32'h0;
      src_last = 4'b0000;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (byte_ack[i] === 1'b1) sp[i]++;
            if (en[i] && sp[i] < sl[i]) begin
               req[i]             = 1'b1;
               src_data[8*i +: 8] = sbytes[i][8*sp[i] +: 8];
               src_last[i]        = smask[i][sp[i]];
            end else begin
               req[i]             = 1'b0;
               src_data[8*i +: 8] = 8'h00;
               src_last[i]        = 1'b0;
            end
         end
      end
   end

   // Byte engine model: tx_done eng_delay cycles after tx_start; 0 means never.
   int eng_delay = 10;
   int eng_cnt   = 0;
   int dn_q[$];

   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               tx_done = 1'b1;
               dn_q.push_back(cyc);
            end
         end
         if (tx_start === 1'b1 && eng_delay > 0) eng_cnt = eng_delay;
      end
   end

   // Event logs.
   int st_cyc[$], st_data[$], st_grant[$], st_ack[$];
   int gr_cyc[$], gr_val[$], err_cyc[$];
   int stray_ack = 0;
   logic [3:0] gprev = 4'b0000;

   initial forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
         st_cyc.push_back(cyc);
         st_data.push_back(int'(tx_data));
         st_grant.push_back(int'(grant));
         st_ack.push_back(int'(byte_ack));
         $display("[TB] cyc %0d tx_start grant=%b byte_ack=%b data=%h", cyc, grant, byte_ack, tx_data);
      end
      if (byte_ack !== 4'b0000 && tx_start !== 1'b1) stray_ack++;
      if (err === 1'b1) err_cyc.push_back(cyc);
      if (grant !== gprev) begin
         gr_cyc.push_back(cyc);
         gr_val.push_back(int'(grant));
         gprev = grant;
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      st_cyc.delete(); st_data.delete(); st_grant.delete(); st_ack.delete();
      gr_cyc.delete(); gr_val.delete(); err_cyc.delete(); dn_q.delete();
   endtask

   task automatic load(input int s, input int n, input logic [31:0] bytes, input logic [3:0] lm);
      sbytes[s] = bytes;
      smask[s]  = lm;
      sl[s]     = n;
      sp[s]     = 0;
      en[s]     = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en[i] = 1'b0;
         sl[i] = 0;
      end
      eng_cnt = 0;
      run_cycles(2);
      rst_n = 1'b1;
      run_cycles(2);
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (st_cyc.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(tag, int'(st_cyc.size() >= n), 1);
   endtask

   task automatic wait_errs(input int n, input int budget, input string tag);
      int k = 0;
      while (err_cyc.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(tag, int'(err_cyc.size() >= n), 1);
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int r;
      int s3;
      int d3;
      int eg[5];
      int ed[5];

      rst_n = 1'b0;
      run_cycles(3);
      check("rst_grant",    int'(grant),    0);
      check("rst_byte_ack", int'(byte_ack), 0);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_tx_data",  int'(tx_data),  0);
      check("rst_err",      int'(err),      0);
      rst_n = 1'b1;
      run_cycles(2);

      // Single source 4-byte packet, source 1 waiting behind it.
      clear_logs();
      eng_delay = 4340;
      r = cyc;
      load(0, 4, 32'h30303032, 4'b1000);
      load(1, 1, 32'h000000A5, 4'b0001);
      wait_starts(4, 20000, "t1_starts");
      eng_delay = 10;
      wait_starts(5, 6000, "t1_next_start");
      run_cycles(600);
      ed = '{32'h32, 32'h30, 32'h30, 32'h30, 32'hA5};
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t1_data%0d", k),  qget(st_data, k),  ed[k]);
         check($sformatf("t1_grant%0d", k), qget(st_grant, k), 1);
         check($sformatf("t1_ack%0d", k),   qget(st_ack, k),   1);
      end
      check("t1_grant_rise", qget(gr_cyc, 0), r + 1);
      check("t1_first_start", qget(st_cyc, 0), r + 2);
      for (int k = 1; k < 4; k++)
         check($sformatf("t1_spacing%0d", k), qget(st_cyc, k) - qget(st_cyc, k - 1), 4342);
      s3 = qget(st_cyc, 3);
      check("t1_fall_val", qget(gr_val, 1), 0);
      check("t1_fall_cyc", qget(gr_cyc, 1), s3 + 4341);
      check("t1_next_grant", qget(gr_val, 2), 2);
      check("t1_next_cyc", qget(gr_cyc, 2), s3 + 4341 + 435);
      check("t1_next_data", qget(st_data, 4), 32'hA5);

      // Round robin from pointer 0 with all four requesting.
      do_reset();
      clear_logs();
      eng_delay = 10;
      load(0, 2, 32'h0000A1A0, 4'b0011);
      load(1, 1, 32'h000000B0, 4'b0001);
      load(2, 1, 32'h000000C0, 4'b0001);
      load(3, 1, 32'h000000D0, 4'b0001);
      wait_starts(5, 4000, "t2_starts");
      run_cycles(600);
      eg = '{1, 2, 4, 8, 1};
      ed = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hA1};
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t2_grant%0d", k), qget(st_grant, k), eg[k]);
         check($sformatf("t2_data%0d", k),  qget(st_data, k),  ed[k]);
      end
      check("t2_packet_gap", qget(st_cyc, 1) - qget(st_cyc, 0), 447);

      // Pointer moved to 3 by serving source 2, then sources 0 and 2.
      clear_logs();
      load(2, 1, 32'h000000E0, 4'b0001);
      wait_starts(1, 100, "t3_setup");
      run_cycles(600);
      clear_logs();
      load(0, 2, 32'h0000F1F0, 4'b0011);
      load(2, 1, 32'h000000E2, 4'b0001);
      wait_starts(3, 3000, "t3_starts");
      run_cycles(600);
      eg = '{1, 4, 1, 0, 0};
      ed = '{32'hF0, 32'hE2, 32'hF1, 0, 0};
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t3_grant%0d", k), qget(st_grant, k), eg[k]);
         check($sformatf("t3_data%0d", k),  qget(st_data, k),  ed[k]);
      end

      // No preemption: source 0 requests during source 1's first byte.
      clear_logs();
      eng_delay = 50;
      load(1, 3, 32'h00332211, 4'b0100);
      wait_starts(1, 100, "t4_first");
      load(0, 1, 32'h00000044, 4'b0001);
      wait_starts(4, 3000, "t4_starts");
      run_cycles(600);
      eg = '{2, 2, 2, 1, 0};
      for (int k = 0; k < 4; k++)
         check($sformatf("t4_grant%0d", k), qget(st_grant, k), eg[k]);
      d3 = qget(dn_q, 2);
      check("t4_fall_val", qget(gr_val, 1), 0);
      check("t4_fall_cyc", qget(gr_cyc, 1), d3 + 1);
      check("t4_src0_val", qget(gr_val, 2), 1);
      check("t4_src0_cyc", qget(gr_cyc, 2), d3 + 436);
      check("t4_src0_data", qget(st_data, 3), 32'h44);

      // Timeout: engine silent for source 3, then source 1 served.
      clear_logs();
      eng_delay = 0;
      load(3, 1, 32'h00000055, 4'b0001);
      wait_starts(1, 100, "t5_first");
      load(1, 1, 32'h00000066, 4'b0001);
      wait_errs(1, 5200, "t5_err_seen");
      eng_delay = 10;
      wait_starts(2, 1000, "t5_next");
      run_cycles(600);
      check("t5_err_cyc", qget(err_cyc, 0), qget(st_cyc, 0) + 5000);
      check("t5_err_count", err_cyc.size(), 1);
      check("t5_fall_val", qget(gr_val, 1), 0);
      check("t5_fall_cyc", qget(gr_cyc, 1), qget(st_cyc, 0) + 5000);
      check("t5_grant0", qget(st_grant, 0), 8);
      check("t5_grant1", qget(st_grant, 1), 2);
      check("t5_data1", qget(st_data, 1), 32'h66);

      // Early drop: source 2 releases req after its first byte.
      clear_logs();
      eng_delay = 30;
      load(2, 3, 32'h00998877, 4'b0100);
      wait_starts(1, 100, "t6_first");
      en[2] = 1'b0;
      run_cycles(600);
      check("t6_start_count", st_cyc.size(), 1);
      check("t6_fall_val", qget(gr_val, 1), 0);
      check("t6_fall_cyc", qget(gr_cyc, 1), qget(dn_q, 0) + 2);
      check("t6_no_err", err_cyc.size(), 0);

      // Asynchronous reset during WAIT, stray tx_done afterwards, then a fresh grant.
      clear_logs();
      eng_delay = 100;
      load(3, 2, 32'h0000D2D1, 4'b0010);
      wait_starts(1, 100, "t7_first");
      run_cycles(5);
      #2;
      rst_n = 1'b0;
      en[3] = 1'b0;
      sl[3] = 0;
      #1;
      check("t7_rst_grant",   int'(grant),    0);
      check("t7_rst_tx_data", int'(tx_data),  0);
      check("t7_rst_start",   int'(tx_start), 0);
      check("t7_rst_ack",     int'(byte_ack), 0);
      check("t7_rst_err",     int'(err),      0);
      run_cycles(3);
      rst_n = 1'b1;
      clear_logs();
      run_cycles(120);
      check("t7_stray_done_seen", dn_q.size(), 1);
      check("t7_idle_starts", st_cyc.size(), 0);
      check("t7_idle_grants", gr_cyc.size(), 0);
      clear_logs();
      eng_delay = 10;
      r = cyc;
      load(1, 1, 32'h000000C3, 4'b0001);
      wait_starts(1, 100, "t7_fresh");
      run_cycles(600);
      check("t7_grant_cyc", qget(gr_cyc, 0), r + 1);
      check("t7_grant_val", qget(gr_val, 0), 2);
      check("t7_start_cyc", qget(st_cyc, 0), r + 2);
      check("t7_data", qget(st_data, 0), 32'hC3);
      check("stray_byte_ack", stray_ack, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART byte transmitter among four message sources. Each source presents bytes through a request/acknowledge handshake. The scheduler grants one source per packet, keeps that grant until the packet's last byte has left the line, and inserts a programmable idle gap between packets. It sits between the message generators (birthday, key, status senders) and the single serial byte engine, which drives tx_start/tx_data and returns tx_done after the stop bit.

## Interface
- GAP_CYCLES, 16'd434: idle clocks between the end of one packet and the next arbitration (one bit time at 115200 baud, 50 MHz).
- DONE_TIMEOUT, 16'd5000: maximum clocks to wait for tx_done after tx_start before the packet is aborted (10 bits × 434 plus margin).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-source level request; source i holds req[i] high while it has bytes to send.
- src_data  in  32  byte presented by source i on src_data[8i+7:8i]; must be valid whenever req[i] is high.
- src_last  in  4  src_last[i] high marks the presented byte as the final byte of the packet.
- grant  out  4  one-hot owner of the transmitter; all zero when idle.
- byte_ack  out  4  one-cycle pulse to source i when its current byte is taken; the source advances to its next byte after this pulse.
- tx_start  out  1  one-cycle pulse to the byte engine.
- tx_data  out  8  byte for the engine; held stable from the tx_start cycle until tx_done.
- tx_done  in  1  one-cycle pulse from the engine when the stop bit completes.
- err  out  1  one-cycle pulse on a tx_done timeout.

## Operation
- States: IDLE, SEND, WAIT, GAP.
- IDLE
  - When req is nonzero, choose the first set bit at or after rr_ptr, searching upward and wrapping 3→0.
  - Register the one-hot grant and go to SEND.
  - Stay in IDLE while req == 0.
- SEND
  - If req of the granted source is high: pulse tx_start and byte_ack[g] for one cycle, latch tx_data = src_data[g], latch last_q = src_last[g], clear the timeout counter, and go to WAIT.
  - If req of the granted source is low: the packet has ended early; go to GAP with no byte sent.
- WAIT
  - Count clocks.
  - On tx_done: if last_q is set, go to GAP; otherwise go to SEND.
  - When the counter reaches DONE_TIMEOUT−1 with no tx_done: pulse err and go to GAP.
  - A tx_done and the timeout in the same cycle count as done; err is not pulsed.
- GAP
  - Clear grant on entry.
  - Set rr_ptr = (granted index + 1) mod 4.
  - Count GAP_CYCLES clocks, then return to IDLE.
  - GAP_CYCLES = 0 means a single GAP cycle.
- Request changes on req from other sources never preempt a packet in progress.
- A tx_done received outside WAIT is ignored.
- Both counters are 16 bits, cleared on state entry, and never wrap: each is compared for equality with its limit.

## Timing
- Reset values:
  - state IDLE
  - grant 0
  - byte_ack 0
  - tx_start 0
  - tx_data 8'h00
  - err 0
  - rr_ptr 0
  - counters 0
- Reset mid-packet returns everything to these values immediately; the byte engine is not told.
- req sampled in cycle N gives grant in N+1, with tx_start and byte_ack in N+2.
- tx_done in cycle M:
  - Not last byte: next tx_start in M+2.
  - Last byte: grant falls in M+1, and the next grant appears at M+1+GAP_CYCLES+1 at the earliest.
- tx_start and byte_ack for the same byte always occur in the same cycle, and there is at most one of each per tx_done.
- grant is constant from the cycle after the IDLE decision until GAP entry.

## Test plan
- Single source: req[0]=1 with bytes 8'h32,8'h30,8'h30,8'h30 and src_last on the fourth; the engine model returns tx_done 4340 clocks after each tx_start → four tx_start pulses carrying 32,30,30,30, four byte_ack[0] pulses, grant 4'b0001 throughout, then grant 0 for 434 clocks.
- Round robin: req=4'b1111 held, one-byte packets → grant order 0,1,2,3,0.
- Round robin with pointer at 3: req=4'b0101 → order 0,2,0.
- No preemption: source 1 granted, sending a 3-byte packet; req[0] rises during byte 1 → source 0 is granted only after source 1's third tx_done plus the gap.
- Timeout: engine never returns tx_done → err pulses exactly 5000 clocks after tx_start, grant clears, then the next requester is served.
- Early drop and reset: req[2] falls after byte 1 of 3 → no further tx_start, GAP entered. rst_n pulsed low during WAIT → all outputs return to reset values asynchronously, and a fresh req is granted normally afterwards.
